// File: rtl/mcpu_ram_ctrl_v2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mcpu_ram_pkg                                                 |
// | Description : Shared types and default constants for the MCPU RAM          |
// |               controller: FSM state enum, default word/address widths and  |
// |               the default fill word.                                       |
// | Revision    : 2.0 - clocked, parametrised controller                      |
// +----------------------------------------------------------------------------+
package mcpu_ram_pkg;

    localparam int unsigned c_DEF_WORD_SIZE  = 8;
    localparam int unsigned c_DEF_ADDR_WIDTH = 8;
    localparam int unsigned c_DEF_FILL_VALUE = 0;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mcpu_ram_ctrl_v2_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mcpu_ram_ctrl_v2_if                                          |
// | Description : Bus bundle between the MCPU core and the RAM controller.     |
// |               Data port: d_req/d_we/d_addr/d_wdata in, d_ready/d_rvalid/   |
// |               d_rdata out. Fetch port: i_req/i_addr in, i_rvalid/i_rdata   |
// |               out. busy flags a running clear sequence.                    |
// |               master = core side, slave = controller side.                 |
// | Revision    : 2.0 - clocked, parametrised controller                      |
// +----------------------------------------------------------------------------+
interface mcpu_ram_ctrl_v2_if
    import mcpu_ram_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = c_DEF_WORD_SIZE,
    parameter int unsigned ADDR_WIDTH = c_DEF_ADDR_WIDTH
) ();

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [WORD_SIZE-1:0]  d_wdata;
    logic                  d_ready;
    logic                  d_rvalid;
    logic [WORD_SIZE-1:0]  d_rdata;
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_rvalid;
    logic [WORD_SIZE-1:0]  i_rdata;
    logic                  busy;

    modport master (
        output d_req, d_we, d_addr, d_wdata, i_req, i_addr,
        input  d_ready, d_rvalid, d_rdata, i_rvalid, i_rdata, busy
    );

    modport slave (
        input  d_req, d_we, d_addr, d_wdata, i_req, i_addr,
        output d_ready, d_rvalid, d_rdata, i_rvalid, i_rdata, busy
    );

endinterface
`default_nettype wire

// File: rtl/mcpu_ram_clear_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mcpu_ram_clear_seq                                           |
// | Description : Post-reset clear sequencer. Walks addresses 0..RAM_SIZE-1,   |
// |               one per cycle, asserting o_we; o_last marks the final write  |
// |               and o_busy drops on the edge that performs it.               |
// |               Ports: clk, rst_n (async, active-low), o_busy, o_we,         |
// |               o_last, o_addr.                                              |
// | Revision    : 2.0 - clocked, parametrised controller                      |
// +----------------------------------------------------------------------------+
module mcpu_ram_clear_seq #(
    parameter int unsigned RAM_SIZE = 256,
    parameter int unsigned IDX_W    = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    output logic                  o_busy,
    output logic                  o_we,
    output logic                  o_last,
    output logic [IDX_W-1:0]      o_addr
);

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(RAM_SIZE - 1);

    logic [IDX_W-1:0] r_addr;
    logic             r_busy;
    logic             w_last;

    assign w_last = r_busy && (r_addr == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (w_last) begin
                r_busy <= 1'b0;
            end else begin
                r_addr <= r_addr + IDX_W'(1);
            end
        end
    end

    assign o_busy = r_busy;
    assign o_we   = r_busy;
    assign o_last = w_last;
    assign o_addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/mcpu_ram_ctrl_v2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mcpu_ram_ctrl_v2                                             |
// | Description : Clocked RAM controller with a read/write data port and a     |
// |               read-only fetch port over one shared array, both with a      |
// |               registered one-cycle read latency. A write and a fetch to    |
// |               the same address on one edge resolve write-first.            |
// |               Out-of-range writes are dropped; out-of-range reads return   |
// |               FILL_VALUE.                                                  |
// |               Ports: clk, rst_n (async, active-low), bus (slave modport).  |
// |               Option macro MCPU_RAM_CLEAR_EN: after reset, fill the whole  |
// |               array with FILL_VALUE before accepting requests.             |
// | Revision    : 2.0 - clocked, parametrised controller                      |
// +----------------------------------------------------------------------------+
module mcpu_ram_ctrl_v2
    import mcpu_ram_pkg::*;
#(
    parameter int unsigned          WORD_SIZE  = c_DEF_WORD_SIZE,
    parameter int unsigned          ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    // Must satisfy 1 <= RAM_SIZE <= 2**ADDR_WIDTH.
    parameter int unsigned          RAM_SIZE   = 1 << ADDR_WIDTH,
    parameter logic [WORD_SIZE-1:0] FILL_VALUE = WORD_SIZE'(c_DEF_FILL_VALUE)
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mcpu_ram_ctrl_v2_if.slave bus
);

    localparam int unsigned             c_IDX_W    = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0]     c_RAM_SIZE = (ADDR_WIDTH + 1)'(RAM_SIZE);

    logic [WORD_SIZE-1:0] r_mem [RAM_SIZE];

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_ready;
    logic                 w_ready_nxt;

    logic                 r_d_rvalid;
    logic [WORD_SIZE-1:0] r_d_rdata;
    logic                 r_i_rvalid;
    logic [WORD_SIZE-1:0] r_i_rdata;

    logic                 w_d_acc;
    logic                 w_i_acc;
    logic                 w_d_inr;
    logic                 w_i_inr;
    logic                 w_wr_en;
    logic                 w_collide;
    logic [c_IDX_W-1:0]   w_d_idx;
    logic [c_IDX_W-1:0]   w_i_idx;

    logic                 w_clr_busy;
    logic                 w_clr_we;
    logic                 w_clr_last;
    logic [c_IDX_W-1:0]   w_clr_addr;

`ifdef MCPU_RAM_CLEAR_EN
    localparam state_t c_ST_RESET = ST_CLEAR;

    mcpu_ram_clear_seq #(
        .RAM_SIZE (RAM_SIZE),
        .IDX_W    (c_IDX_W)
    ) u_clear_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_busy (w_clr_busy),
        .o_we   (w_clr_we),
        .o_last (w_clr_last),
        .o_addr (w_clr_addr)
    );
`else
    localparam state_t c_ST_RESET = ST_RUN;

    assign w_clr_busy = 1'b0;
    assign w_clr_we   = 1'b0;
    assign w_clr_last = 1'b0;
    assign w_clr_addr = '0;
`endif

    // ---------------------------------------------------------------- FSM
    // d_ready is a registered output loaded from the next state, so it is low
    // during reset and rises on the same edge the FSM enters RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_RESET;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (w_clr_last) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = c_ST_RESET;
        endcase
    end

    always_comb begin
        w_ready_nxt = 1'b0;
        if (w_state_nxt == ST_RUN) begin
            w_ready_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------- port decode
    // The fetch port shares the data port's ready.
    assign w_d_acc   = bus.d_req && r_ready;
    assign w_i_acc   = bus.i_req && r_ready;
    assign w_d_inr   = ({1'b0, bus.d_addr} < c_RAM_SIZE);
    assign w_i_inr   = ({1'b0, bus.i_addr} < c_RAM_SIZE);
    assign w_d_idx   = bus.d_addr[c_IDX_W-1:0];
    assign w_i_idx   = bus.i_addr[c_IDX_W-1:0];
    assign w_wr_en   = w_d_acc && bus.d_we && w_d_inr;
    // Only a write that really lands is forwarded to the fetch port.
    assign w_collide = w_wr_en && (bus.d_addr == bus.i_addr);

    // ------------------------------------------------------------ memory
    // No reset here: contents survive reset except through the clear walk.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= FILL_VALUE;
        end else if (w_wr_en) begin
            r_mem[w_d_idx] <= bus.d_wdata;
        end
    end

    // ------------------------------------------------------- read ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_rvalid <= 1'b0;
            r_d_rdata  <= '0;
            r_i_rvalid <= 1'b0;
            r_i_rdata  <= '0;
        end else begin
            r_d_rvalid <= w_d_acc && !bus.d_we;
            r_i_rvalid <= w_i_acc;
            if (w_d_acc && !bus.d_we) begin
                r_d_rdata <= w_d_inr ? r_mem[w_d_idx] : FILL_VALUE;
            end
            if (w_i_acc) begin
                if (!w_i_inr) begin
                    r_i_rdata <= FILL_VALUE;
                end else if (w_collide) begin
                    r_i_rdata <= bus.d_wdata;
                end else begin
                    r_i_rdata <= r_mem[w_i_idx];
                end
            end
        end
    end

    assign bus.d_ready  = r_ready;
    assign bus.d_rvalid = r_d_rvalid;
    assign bus.d_rdata  = r_d_rdata;
    assign bus.i_rvalid = r_i_rvalid;
    assign bus.i_rdata  = r_i_rdata;
    assign bus.busy     = w_clr_busy;

endmodule
`default_nettype wire

// File: doc/mcpu_ram_ctrl_v2.md
# mcpu_ram_ctrl_v2

Clocked, parametrised successor to the MicroCPU combinational RAM controller. It provides one data port (read/write, with a request/ready handshake) and one instruction-fetch port (read-only), both with registered one-cycle read latency, over a single shared memory array. Word size, address width and depth are generalised. Same-cycle write/fetch collisions are resolved deterministically. It sits between the MCPU core's load/store and fetch units and the on-chip memory.

## Interface
Parameters:
- WORD_SIZE, 8, data word width in bits
- ADDR_WIDTH, 8, address width in bits
- RAM_SIZE, 1<<ADDR_WIDTH, number of words; must satisfy 1 ≤ RAM_SIZE ≤ 2^ADDR_WIDTH
- FILL_VALUE, 0, word written by the clear sequence and returned for out-of-range reads

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- d_req  in  1  data-port request
- d_we  in  1  1 = write, 0 = read; sampled with d_req
- d_addr  in  ADDR_WIDTH  data-port address
- d_wdata  in  WORD_SIZE  write data
- d_ready  out  1  controller accepts data requests
- d_rvalid  out  1  one-cycle pulse: d_rdata valid
- d_rdata  out  WORD_SIZE  data-port read data
- i_req  in  1  fetch request
- i_addr  in  ADDR_WIDTH  fetch address
- i_rvalid  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  WORD_SIZE  fetched word
- busy  out  1  clear sequence in progress

## Operation
- FSM states: CLEAR and RUN. The CLEAR state exists only with the config macro defined.
- A data transfer occurs on a rising edge where d_req && d_ready. A fetch occurs on a rising edge where i_req && d_ready. The fetch port has no separate ready.
- Write: mem[d_addr] <= d_wdata at the accepting edge. No d_rvalid is generated.
- Read: on the next cycle, d_rdata = mem[d_addr] and d_rvalid = 1.
- Fetch: on the next cycle, i_rdata = mem[i_addr] and i_rvalid = 1.
- Collision (data write and fetch to the same address on the same edge): write-first. i_rdata returns d_wdata.
- d_rdata and i_rdata hold their last value while the corresponding rvalid is 0.
- Out-of-range address (addr ≥ RAM_SIZE):
  - Writes are dropped.
  - Reads and fetches return FILL_VALUE, with rvalid still pulsed.
- Back-to-back requests on every cycle are supported, giving a throughput of 1 per port per cycle.

## Timing
- While rst_n = 0, outputs are: d_ready = 0, d_rvalid = 0, i_rvalid = 0, d_rdata = 0, i_rdata = 0. busy = 1 with the macro, 0 without it.
- Reset has no effect on memory contents except through the clear sequence.
- Without the macro, d_ready rises on the first rising edge after rst_n deasserts.
- Read/fetch latency is exactly 1 cycle from the accepting edge.
- Requests presented while d_ready = 0 are ignored; they are not queued.
- Asserting rst_n mid-operation aborts any pending rvalid. With the macro, it restarts the clear sequence at address 0.

## Configuration
- MCPU_RAM_CLEAR_EN defined:
  - After reset, the controller enters CLEAR and writes FILL_VALUE to address 0..RAM_SIZE-1, one word per cycle.
  - busy = 1 and d_ready = 0 throughout the sequence.
  - After the final write, the FSM moves to RUN: busy falls and d_ready rises on the same edge.
  - The sequence takes exactly RAM_SIZE cycles after reset release.
- MCPU_RAM_CLEAR_EN undefined:
  - There is no CLEAR state; busy is tied to 0.
  - Memory powers up undefined.
  - d_ready = 1 one edge after reset release.

## Structure
- Package mcpu_ram_pkg contains:
  - the FSM state enum (ST_CLEAR, ST_RUN)
  - default constants for WORD_SIZE and ADDR_WIDTH
  - the FILL_VALUE default
- Sub-module mcpu_ram_clear_seq contains the clear-address counter, terminal-count detection and the busy flag. It is instantiated only under MCPU_RAM_CLEAR_EN.
- The memory array, port logic and collision logic stay in the top module.

## Test plan
- Clear with macro, RAM_SIZE = 256, FILL_VALUE = 0:
  - Release reset -> busy is high for exactly 256 cycles, then d_ready = 1.
  - Reads of addresses 0, 128 and 255 return 0.
- Write/read pattern (4, 8, 1, 9 repeating) to addresses 0..255, then read each back on the data port and fetch it on the instruction port -> both return the identical pattern, with 1-cycle latency and rvalid pulses.
- Collision: write 0xA5 to address 0x10 while fetching 0x10 on the same edge -> i_rdata = 0xA5 on the next cycle.
- Out of range, with RAM_SIZE = 200:
  - Write 0x33 to address 210 -> the write is dropped.
  - A read of 210 returns FILL_VALUE with d_rvalid = 1.
- Reset mid-clear: assert rst_n low at clear cycle 100, then release -> the clear restarts and busy stays high for 256 further cycles.
- Request while d_ready = 0: a read issued during clear -> no d_rvalid, no state change.
